// File: rtl/quant_seq_ctrl.sv
// Quantization sequencer: walks one MCU (NUM_Y luma, Cb, Cr blocks),
// handshakes DCT rows and drains the quantizer pipe per block.
module quant_seq_ctrl #(
  parameter int NUM_Y = 4,
  parameter int QLAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dct_valid,
  output logic        dct_ready,
  input  logic        zz_ready,
  output logic        enable_y,
  output logic        enable_cb,
  output logic        enable_cr,
  output logic        enable_quant,
  output logic [2:0]  row_cnt,
  output logic [2:0]  blk_idx,
  output logic        blk_done,
  output logic        mcu_done,
  output logic        busy,
  output logic [14:0] quant_cycle
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN
  } state_t;

  localparam logic [2:0] NY_B     = 3'(NUM_Y);
  localparam logic [2:0] LAST_BLK = 3'(NUM_Y + 1);
  localparam logic [3:0] DRN_LAST = 4'(QLAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  blk_q, blk_d;
  logic [3:0]  drn_q, drn_d;
  logic [2:0]  mode_q, mode_d;
  logic [14:0] qc_q;

  // State, counters and the registered table select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      blk_q   <= '0;
      drn_q   <= '0;
      mode_q  <= '0;
      qc_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      drn_q   <= drn_d;
      mode_q  <= mode_d;
      if (enable_quant)
        qc_q <= qc_q + 15'd1;
    end
  end

  // Next-state, row/block/drain counters and strobes.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    blk_d        = blk_q;
    drn_d        = drn_q;
    dct_ready    = 1'b0;
    enable_quant = 1'b0;
    blk_done     = 1'b0;
    mcu_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = SETUP;
      end
      SETUP: begin
        drn_d = '0;
        if (zz_ready)
          state_d = RUN;
      end
      RUN: begin
        dct_ready = 1'b1;
        if (dct_valid) begin
          enable_quant = 1'b1;
          row_d        = row_q + 3'd1;
          if (row_q == 3'd7)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        drn_d = drn_q + 4'd1;
        if (drn_q == DRN_LAST) begin
          blk_done = 1'b1;
          drn_d    = '0;
          if (blk_q == LAST_BLK) begin
            mcu_done = 1'b1;
            blk_d    = '0;
            state_d  = IDLE;
          end else begin
            blk_d   = blk_q + 3'd1;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select follows the block index of the state being entered;
  // blk_d only moves on SETUP entry so rows never see a change.
  always_comb begin
    mode_d = 3'b000;
    if (state_d != IDLE) begin
      if (blk_d < NY_B)
        mode_d = 3'b100;
      else if (blk_d == NY_B)
        mode_d = 3'b010;
      else
        mode_d = 3'b001;
    end
  end

  assign enable_y    = mode_q[2];
  assign enable_cb   = mode_q[1];
  assign enable_cr   = mode_q[0];
  assign row_cnt     = row_q;
  assign blk_idx     = blk_q;
  assign busy        = (state_q != IDLE);
  assign quant_cycle = qc_q;

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Self-checking bench for quant_seq_ctrl: table-driven nominal MCU,
// row scoreboard, and hand sequences for stall/ignore/reset cases.
module tb_quant_seq_ctrl;

  localparam int NY = 4;
  localparam int QL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dct_valid;
  logic        dct_ready;
  logic        zz_ready;
  logic        enable_y;
  logic        enable_cb;
  logic        enable_cr;
  logic        enable_quant;
  logic [2:0]  row_cnt;
  logic [2:0]  blk_idx;
  logic        blk_done;
  logic        mcu_done;
  logic        busy;
  logic [14:0] quant_cycle;

  quant_seq_ctrl #(.NUM_Y(NY), .QLAT(QL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dct_valid   (dct_valid),
    .dct_ready   (dct_ready),
    .zz_ready    (zz_ready),
    .enable_y    (enable_y),
    .enable_cb   (enable_cb),
    .enable_cr   (enable_cr),
    .enable_quant(enable_quant),
    .row_cnt     (row_cnt),
    .blk_idx     (blk_idx),
    .blk_done    (blk_done),
    .mcu_done    (mcu_done),
    .busy        (busy),
    .quant_cycle (quant_cycle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcu_cnt = 0;

  wire [2:0] mode = {enable_y, enable_cb, enable_cr};

  typedef struct {
    logic [2:0] blk;
    logic [2:0] row;
    logic [2:0] mode;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int          cyc;
    logic        eq;
    logic        bd;
    logic        md;
    logic        bsy;
    logic [2:0]  blk;
    logic [2:0]  mode;
    logic [14:0] qc;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [2:0] exp_mode(input int b);
    if (b < NY) return 3'b100;
    if (b == NY) return 3'b010;
    return 3'b001;
  endfunction

  task automatic push_mcu();
    sb_t e;
    for (int b = 0; b <= NY + 1; b++)
      for (int r = 0; r < 8; r++) begin
        e.blk  = 3'(b);
        e.row  = 3'(r);
        e.mode = exp_mode(b);
        sb.push_back(e);
      end
  endtask

  // Row scoreboard and per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("eq_is_valid_and_ready", 32'(enable_quant),
          32'(dct_valid & dct_ready));
      if (busy)
        chk("select_onehot", 32'($onehot(mode)), 1);
      else
        chk("select_idle_zero", 32'(mode), 0);
      if (enable_quant) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_row", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_blk", 32'(blk_idx), 32'(e.blk));
          chk("sb_row", 32'(row_cnt), 32'(e.row));
          chk("sb_mode", 32'(mode), 32'(e.mode));
        end
      end
      if (mcu_done) begin
        mcu_cnt++;
        chk("mcu_with_blk_done", 32'(blk_done), 1);
        chk("mcu_blk_idx", 32'(blk_idx), NY + 1);
        chk("mcu_cr", 32'(mode), 32'b001);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_mcu(input bit gap, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = mcu_done;
      next_cyc();
      if (gap) dct_valid = ~dct_valid;
    end
    chk("mcu_done_seen", 32'(seen), 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    int m0;
    bit done;

    tbl[0]  = '{0,  0, 0, 0, 0, 3'd0, 3'b000, 15'd0};
    tbl[1]  = '{1,  0, 0, 0, 1, 3'd0, 3'b100, 15'd0};
    tbl[2]  = '{2,  1, 0, 0, 1, 3'd0, 3'b100, 15'd0};
    tbl[3]  = '{9,  1, 0, 0, 1, 3'd0, 3'b100, 15'd7};
    tbl[4]  = '{10, 0, 0, 0, 1, 3'd0, 3'b100, 15'd8};
    tbl[5]  = '{11, 0, 1, 0, 1, 3'd0, 3'b100, 15'd8};
    tbl[6]  = '{12, 0, 0, 0, 1, 3'd1, 3'b100, 15'd8};
    tbl[7]  = '{13, 1, 0, 0, 1, 3'd1, 3'b100, 15'd8};
    tbl[8]  = '{45, 0, 0, 0, 1, 3'd4, 3'b010, 15'd32};
    tbl[9]  = '{46, 1, 0, 0, 1, 3'd4, 3'b010, 15'd32};
    tbl[10] = '{55, 0, 1, 0, 1, 3'd4, 3'b010, 15'd40};
    tbl[11] = '{56, 0, 0, 0, 1, 3'd5, 3'b001, 15'd40};
    tbl[12] = '{66, 0, 1, 1, 1, 3'd5, 3'b001, 15'd48};
    tbl[13] = '{67, 0, 0, 0, 0, 3'd0, 3'b000, 15'd48};

    rst = 1'b1;
    start = 1'b0;
    dct_valid = 1'b0;
    zz_ready = 1'b0;
    repeat (3) next_cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_qc", 32'(quant_cycle), 0);
    chk("rst_blk", 32'(blk_idx), 0);
    rst = 1'b0;
    next_cyc();

    // Nominal MCU, continuous valid, table of checkpoints.
    push_mcu();
    zz_ready = 1'b1;
    dct_valid = 1'b1;
    for (int c = 0; c <= 67; c++) begin
      start = (c == 0);
      @(negedge clk);
      foreach (tbl[k]) begin
        if (tbl[k].cyc == c) begin
          chk("t_eq", 32'(enable_quant), 32'(tbl[k].eq));
          chk("t_blk_done", 32'(blk_done), 32'(tbl[k].bd));
          chk("t_mcu_done", 32'(mcu_done), 32'(tbl[k].md));
          chk("t_busy", 32'(busy), 32'(tbl[k].bsy));
          chk("t_blk_idx", 32'(blk_idx), 32'(tbl[k].blk));
          chk("t_mode", 32'(mode), 32'(tbl[k].mode));
          chk("t_qc", 32'(quant_cycle), 32'(tbl[k].qc));
        end
      end
      next_cyc();
    end
    start = 1'b0;
    chk("nom_sb_empty", sb.size(), 0);
    chk("nom_mcu_cnt", mcu_cnt, 1);

    // Alternating valid: 8 rows take 15 RUN cycles.
    push_mcu();
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      start = (c == 0);
      dct_valid = (c % 2 == 0);
      @(negedge clk);
      if (c == 3) begin
        chk("gap_row_hold", 32'(row_cnt), 1);
        chk("gap_no_eq", 32'(enable_quant), 0);
      end
      if (dct_ready) n++;
      done = blk_done;
      next_cyc();
    end
    start = 1'b0;
    chk("gap_run_len", n, 15);
    finish_mcu(1'b1, 400);

    // zz_ready held low for 5 cycles at SETUP of block 2.
    push_mcu();
    dct_valid = 1'b1;
    for (int c = 0; c <= 29; c++) begin
      start = (c == 0);
      zz_ready = !(c >= 23 && c <= 27);
      @(negedge clk);
      if (c >= 23 && c <= 28) begin
        chk("zz_hold_ready", 32'(dct_ready), 0);
        chk("zz_hold_mode", 32'(mode), 32'b100);
        chk("zz_hold_blk", 32'(blk_idx), 2);
      end
      if (c == 29)
        chk("zz_run", 32'(dct_ready), 1);
      next_cyc();
    end
    start = 1'b0;
    zz_ready = 1'b1;
    finish_mcu(1'b0, 200);

    // start pulsed during RUN of block 1 is ignored.
    push_mcu();
    m0 = mcu_cnt;
    for (int c = 0; c <= 15; c++) begin
      start = (c == 0 || c == 15);
      @(negedge clk);
      if (c == 15) begin
        chk("ign_in_run", 32'(dct_ready), 1);
        chk("ign_blk1", 32'(blk_idx), 1);
      end
      next_cyc();
    end
    start = 1'b0;
    finish_mcu(1'b0, 200);
    chk("ign_one_mcu", mcu_cnt - m0, 1);

    // Restart one cycle after mcu_done, then reset mid-block 3.
    push_mcu();
    start = 1'b1;
    @(negedge clk);
    chk("restart_idle", 32'(busy), 0);
    next_cyc();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("restart_busy", 32'(busy), 1);
        chk("restart_blk0", 32'(blk_idx), 0);
        chk("restart_y", 32'(mode), 32'b100);
      end
      if (c == 40) begin
        chk("pre_rst_row", 32'(row_cnt), 5);
        chk("pre_rst_blk", 32'(blk_idx), 3);
        rst = 1'b1;
        #1;
        chk("arst_outs", 32'({dct_ready, mode, enable_quant, blk_done,
            mcu_done, busy}), 0);
        chk("arst_row", 32'(row_cnt), 0);
        chk("arst_blk", 32'(blk_idx), 0);
        chk("arst_qc", 32'(quant_cycle), 0);
      end else begin
        next_cyc();
      end
    end
    sb.delete();
    next_cyc();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 0);
      next_cyc();
    end
    chk("post_rst_qc", 32'(quant_cycle), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule

// File: doc/quant_seq_ctrl.md
Name: quant_seq_ctrl

Overview:
- Sequencer for the row-parallel quantization datapath: 8 coefficients per row, 8 rows per 8x8 block.
- Walks one MCU block by block: NUM_Y luma blocks, then one Cb block, then one Cr block.
- Drives the one-hot Y/Cb/Cr mode selects and the per-row enable_quant strobe.
- Handshakes rows from the DCT stage, waits for the zigzag stage before each block, and covers the quantizer pipeline latency before declaring a block done.

Parameters:
NUM_Y, 4, luma blocks per MCU; legal range 1..6.
QLAT, 2, drain cycles after the last row of a block, covering quantizer latency to enable_zzscan; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  single-cycle pulse that begins one MCU; honoured only in IDLE.
dct_valid  input  1  DCT row data valid this cycle.
dct_ready  output  1  controller accepts a row this cycle.
zz_ready  input  1  zigzag stage can accept a new block.
enable_y  output  1  luma table select.
enable_cb  output  1  Cb table select.
enable_cr  output  1  Cr table select.
enable_quant  output  1  quantize the current row; equals dct_valid AND dct_ready.
row_cnt  output  3  rows accepted in the current block.
blk_idx  output  3  block index within the MCU, 0..NUM_Y+1.
blk_done  output  1  one-cycle pulse when a block has fully drained.
mcu_done  output  1  one-cycle pulse when the last block of the MCU is done.
busy  output  1  high in every state except IDLE.
quant_cycle  output  15  running count of enable_quant cycles.

Behaviour:
- Reset (asynchronous, immediate, including mid-block):
  - state=IDLE.
  - All 1-bit outputs 0.
  - row_cnt=0, blk_idx=0, quant_cycle=0.
- States:
  - IDLE: start=1 -> SETUP. Otherwise stay.
  - SETUP: drive the mode select for blk_idx. Stay while zz_ready=0; zz_ready=1 -> RUN.
  - RUN: dct_ready=1. Each cycle with dct_valid=1: enable_quant=1 and row_cnt+1. The accept at row_cnt=7 wraps row_cnt to 0 and moves to DRAIN.
  - DRAIN: dct_ready=0; internal counter runs QLAT cycles. In the last DRAIN cycle blk_done=1, then:
    - If blk_idx=NUM_Y+1: mcu_done=1 in the same cycle, blk_idx -> 0, go to IDLE.
    - Otherwise: blk_idx+1, go to SETUP.
- Mode decode:
  - Registered and one-hot in SETUP, RUN and DRAIN; all 0 in IDLE.
  - blk_idx < NUM_Y -> enable_y.
  - blk_idx = NUM_Y -> enable_cb.
  - blk_idx = NUM_Y+1 -> enable_cr.
  - Mode changes only on the SETUP entry cycle, never while rows are in flight.
- Handshake:
  - enable_quant is combinational from dct_valid and the RUN state, so the row data and the strobe arrive in the same cycle.
  - dct_valid outside RUN is ignored: no enable_quant, no count.
  - Gaps in dct_valid during RUN stall row_cnt.
- Ignored inputs:
  - start while busy=1 is ignored; the MCU in progress is unaffected.
  - zz_ready is sampled only in SETUP.
- quant_cycle: increments on every enable_quant, wraps 32767 -> 0, cleared only by rst.
- Nominal timing (zz_ready=1, continuous dct_valid): 11 cycles per block.
  - SETUP 1 cycle, RUN 8 cycles, DRAIN QLAT=2 cycles.
- Width: blk_idx is 3 bits, so NUM_Y+1 ≤ 7.

Test Plan:
- Reset, then start at cycle 0, NUM_Y=4, QLAT=2, zz_ready=1, dct_valid=1 continuous -> enable_quant high cycles 2-9, blk_done at cycle 11, second block RUN from cycle 13; mcu_done at cycle 66 with blk_idx=5 and enable_cr=1 in that cycle; quant_cycle=48; IDLE at cycle 67.
- Mode sequence over one MCU -> enable_y for blk_idx 0-3, enable_cb for 4, enable_cr for 5; never two selects high; all low in IDLE.
- dct_valid toggled 1,0,1,0 in RUN -> row_cnt advances only on valid cycles; block RUN lasts 15 cycles for 8 rows; dct_valid asserted in SETUP/DRAIN gives no enable_quant.
- zz_ready=0 for 5 cycles at SETUP of block 2 -> controller holds SETUP 5 extra cycles with dct_ready=0, then RUN; enable_y stays stable throughout.
- start pulsed during RUN of block 1 -> ignored; exactly one mcu_done; a start one cycle after mcu_done begins a new MCU at blk_idx=0.
- rst asserted at row_cnt=5 of block 3 -> all outputs 0 immediately with quant_cycle=0; after release, no activity until start.
